vlsu_seq: RTL and testbench

Element sequencer for vector loads and stores. It holds the vector-length register, accepts a start command from the processor's execute stage, and walks the element index from 0 to VL-1. For each element it issues one word request to data memory through a req/ack handshake, supplies the element index to the vector register file and, for loads, the write strobe. The processor FSM stays in its execute state until `done` is seen.

---
 rtl/vlsu_seq.sv | 135 +++++++++++++
 tb/tb_vlsu_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_seq.sv
// Vector load/store element sequencer: holds VL and walks element
// indices, issuing one word request per element via req/ack.
module vlsu_seq #(
    parameter int NUM_ELEM = 16,
    parameter int IDX_W    = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_vl_wr,
    input  logic [IDX_W:0]    i_vl_val,
    input  logic              i_start,
    input  logic              i_is_store,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_stride,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    output logic [IDX_W-1:0]  o_ele_idx,
    output logic              o_vreg_we,
    output logic              o_busy,
    output logic              o_done,
    output logic [IDX_W:0]    o_vl
);

    localparam logic [IDX_W:0] MAX_VL = (IDX_W+1)'(NUM_ELEM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W:0]      r_vl;
    logic [IDX_W:0]      r_len;
    logic [IDX_W-1:0]    r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_stride;
    logic                r_store;
    logic [IDX_W:0]      w_vl_clamp;
    logic                w_last;

    assign w_vl_clamp = (i_vl_val > MAX_VL) ? MAX_VL : i_vl_val;
    // r_len is the VL latched at start, so a same-cycle VL write
    // cannot change the length of the operation it coincides with.
    assign w_last     = ({1'b0, r_idx} == (r_len - 1'b1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (r_vl == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_mem_ack && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_req = 1'b0;
        o_mem_we  = 1'b0;
        o_vreg_we = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            S_ISSUE: begin
                o_mem_req = 1'b1;
                o_mem_we  = r_store;
                o_vreg_we = i_mem_ack & ~r_store;
                o_busy    = 1'b1;
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_vl     <= MAX_VL;
            r_len    <= '0;
            r_idx    <= '0;
            r_addr   <= '0;
            r_stride <= '0;
            r_store  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_vl_wr) begin
                        r_vl <= w_vl_clamp;
                    end
                    if (i_start) begin
                        r_len    <= r_vl;
                        r_idx    <= '0;
                        r_addr   <= i_base_addr;
                        r_stride <= i_stride;
                        r_store  <= i_is_store;
                    end
                end
                S_ISSUE: begin
                    if (i_mem_ack && !w_last) begin
                        r_idx  <= r_idx + 1'b1;
                        r_addr <= r_addr + r_stride;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr = r_addr;
    assign o_ele_idx  = r_idx;
    assign o_vl       = r_vl;

endmodule

// File: tb/tb_vlsu_seq.sv
// Self-checking bench for vlsu_seq: per-cycle expectations come from an
// element-count model (element k lives at base + k*stride).
module tb_vlsu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vl_wr = 1'b0;
    logic [4:0]  vl_val = '0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] stride = '0;
    logic        mem_ack = 1'b0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_ele_idx;
    logic        o_vreg_we;
    logic        o_busy;
    logic        o_done;
    logic [4:0]  o_vl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vlsu_seq #(.NUM_ELEM(16), .IDX_W(4), .ADDR_W(32)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_vl_wr    (vl_wr),
        .i_vl_val   (vl_val),
        .i_start    (start),
        .i_is_store (is_store),
        .i_base_addr(base_addr),
        .i_stride   (stride),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .i_mem_ack  (mem_ack),
        .o_ele_idx  (o_ele_idx),
        .o_vreg_we  (o_vreg_we),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_vl       (o_vl)
    );

    task automatic set_vl(input int v, input int exp_vl);
        @(posedge clk); #1;
        vl_wr  = 1'b1;
        vl_val = 5'(v);
        @(posedge clk); #1;
        vl_wr = 1'b0;
        #1;
        checks++;
        if (o_vl !== 5'(exp_vl)) begin
            errors++;
            $display("FAIL vl_write val=%0d got=%0d exp=%0d", v, o_vl, exp_vl);
        end
    endtask

    // mode 0: ack always high, 1: two wait cycles per request, 2: random ack
    task automatic run_op(input string name, input int vl, input bit st,
                          input logic [31:0] base, input logic [31:0] str,
                          input int mode, input int inj, input bit wr_at_start,
                          input int vl_after);
        logic [40:0] got, exp;
        logic [31:0] addr_e;
        logic [3:0]  idx_e;
        int k, w, c, c_done, exp_done;
        bit ack, seen;
        @(posedge clk); #1;
        start     = 1'b1;
        is_store  = st;
        base_addr = base;
        stride    = str;
        if (wr_at_start) begin
            vl_wr  = 1'b1;
            vl_val = 5'd2;
        end
        k = 0; w = 0; c = 0; c_done = 0; seen = 1'b0;
        while (!seen && c < 300) begin
            @(posedge clk); #1;
            c++;
            start     = 1'b0;
            vl_wr     = 1'b0;
            base_addr = $urandom;
            stride    = $urandom;
            is_store  = 1'($urandom);
            if (c == inj) begin
                start  = 1'b1;
                vl_wr  = 1'b1;
                vl_val = 5'd2;
            end
            case (mode)
                0:       ack = 1'b1;
                1:       ack = (w == 2);
                default: ack = ($urandom % 4) != 0;
            endcase
            if (k >= vl) ack = 1'b0;
            mem_ack = ack;
            #1;
            got = {o_mem_req, o_mem_we, o_mem_addr, o_ele_idx,
                   o_vreg_we, o_busy, o_done};
            checks++;
            if (k < vl) begin
                addr_e = base + str * 32'(k);
                idx_e  = 4'(k);
                exp = {1'b1, st, addr_e, idx_e, ack & ~st, 1'b1, 1'b0};
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s elem cyc=%0d got=%h exp=%h",
                             name, c, got, exp);
                end
                if (ack) begin
                    k++;
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                if ({o_mem_req, o_vreg_we, o_busy, o_done} !== 4'b0011) begin
                    errors++;
                    $display("FAIL %s done cyc=%0d got=%b exp=0011", name, c,
                             {o_mem_req, o_vreg_we, o_busy, o_done});
                end
                seen   = 1'b1;
                c_done = c;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout got=no_done exp=done", name);
        end
        if (mode < 2) begin
            exp_done = (mode == 0) ? vl + 1 : 3 * vl + 1;
            checks++;
            if (c_done != exp_done) begin
                errors++;
                $display("FAIL %s latency got=%0d exp=%0d", name, c_done, exp_done);
            end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({o_mem_req, o_busy, o_done, o_vl} !== {3'b000, 5'(vl_after)}) begin
            errors++;
            $display("FAIL %s after got=%b/%0d exp=000/%0d", name,
                     {o_mem_req, o_busy, o_done}, o_vl, vl_after);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_ele_idx, o_vreg_we,
             o_busy, o_done} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {o_mem_req, o_mem_we, o_mem_addr, o_ele_idx,
                      o_vreg_we, o_busy, o_done});
        end
        checks++;
        if (o_vl !== 5'd16) begin
            errors++;
            $display("FAIL reset_vl got=%0d exp=16", o_vl);
        end
        rst = 1'b0;
        set_vl(5, 5);
        set_vl(20, 16);
    endtask

    task automatic test_unit_load;
        set_vl(4, 4);
        run_op("unit_load", 4, 1'b0, 32'h100, 32'h1, 0, -1, 1'b0, 4);
    endtask

    task automatic test_neg_store;
        set_vl(3, 3);
        run_op("neg_store", 3, 1'b1, 32'h10, 32'hFFFF_FFFE, 1, -1, 1'b0, 3);
    endtask

    task automatic test_boundary;
        set_vl(0, 0);
        run_op("vl_zero", 0, 1'b0, $urandom, $urandom, 0, -1, 1'b0, 0);
        set_vl(2, 2);
        run_op("addr_wrap", 2, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, -1, 1'b0, 2);
    endtask

    task automatic test_ignored;
        set_vl(4, 4);
        run_op("ignored", 4, 1'b0, 32'h200, 32'h4, 0, 2, 1'b0, 4);
        run_op("start_vlwr", 4, 1'b1, 32'h300, 32'h8, 0, -1, 1'b1, 2);
    endtask

    task automatic test_reset_mid;
        set_vl(8, 8);
        @(posedge clk); #1;
        start     = 1'b1;
        is_store  = 1'b0;
        base_addr = 32'h40;
        stride    = 32'h1;
        @(posedge clk); #1;
        start   = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({o_mem_req, o_busy, o_done, o_vl} !== {3'b000, 5'd16}) begin
            errors++;
            $display("FAIL reset_mid got=%b/%0d exp=000/16",
                     {o_mem_req, o_busy, o_done}, o_vl);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            mem_ack = 1'($urandom);
            #1;
            checks++;
            if ({o_mem_req, o_done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_quiet cyc=%0d got=%b exp=00", i,
                         {o_mem_req, o_done});
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random;
        int v;
        for (int i = 0; i < 8; i++) begin
            v = $urandom_range(1, 16);
            set_vl(v, v);
            run_op("random", v, 1'($urandom), $urandom, $urandom, 2, -1, 1'b0, v);
        end
    endtask

    initial begin
        test_reset;
        test_unit_load;
        test_neg_store;
        test_boundary;
        test_ignored;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
